fetch: RTL and testbench

- Instruction fetch unit that feeds the decode stage.
- Owns the fetch PC and issues word reads on a simple req/ack instruction-memory port.
- Buffers returned words in a small FIFO and presents them to decode with a valid/ready handshake.
- Consumes decode's PC increment (2 or 4) on each pop; handles branch/jump redirects from execute, and any increment other than 4 as a self-redirect.

---
 rtl/fetch_pkg.sv | 18 +
 rtl/fetch_fifo.sv | 54 +++++
 rtl/fetch.sv | 120 ++++++++++++
 tb/tb_fetch.sv | 288 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: FSM encoding,
// the sequential PC step and the default reset PC.
package fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_REQ     = 2'd1,
    ST_DISCARD = 2'd2
  } state_t;

  localparam logic [31:0] PC_INCR_WORD     = 32'd4;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer between the memory port and decode.
// Entries are {pc, data}; the head is readable combinationally.
module fetch_fifo #(
  parameter  int FIFO_DEPTH = 2,
  localparam int AW         = $clog2(FIFO_DEPTH),
  localparam int CW         = AW + 1
) (
  input  logic          I_clk,
  input  logic          I_rst,
  input  logic          I_flush,
  input  logic          I_push,
  input  logic [63:0]   I_push_data,
  input  logic          I_pop,
  output logic          O_full,
  output logic          O_empty,
  output logic [CW-1:0] O_count,
  output logic [63:0]   O_head
);

  logic [63:0]   r_mem [FIFO_DEPTH];
  logic [AW-1:0] r_wr_ptr;
  logic [AW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;
  logic          w_wr_en;

  assign w_wr_en = I_push && !I_flush;

  // Storage carries no reset: validity is tracked by the count alone.
  always_ff @(posedge I_clk) begin
    if (w_wr_en) r_mem[r_wr_ptr] <= I_push_data;
  end

  always_ff @(posedge I_clk) begin
    if (I_rst || I_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (I_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (I_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({I_push, I_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign O_count = r_count;
  assign O_full  = (r_count == CW'(FIFO_DEPTH));
  assign O_empty = (r_count == '0);
  assign O_head  = r_mem[r_rd_ptr];

endmodule

// File: rtl/fetch.sv
// Instruction fetch unit: owns the fetch PC, issues single-outstanding word
// reads, buffers returned words and hands them to decode with valid/ready.
module fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        I_clk,
  input  logic        I_rst,
  input  logic [31:0] I_pcincr,
  input  logic        I_redirect,
  input  logic [31:0] I_target,
  output logic        O_mem_req,
  output logic [31:0] O_mem_addr,
  input  logic        I_mem_ack,
  input  logic [31:0] I_mem_data,
  output logic        O_valid,
  output logic [31:0] O_data,
  output logic [31:0] O_pc,
  input  logic        I_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  state_t        r_state, w_state_next;
  logic [31:0]   r_fetch_pc, w_fetch_pc_next;
  logic [31:0]   r_pend_pc, w_pend_pc_next;

  logic          w_full, w_empty;
  logic [CW-1:0] w_count, w_count_after;
  logic [63:0]   w_head;
  logic [31:0]   w_head_pc, w_target;
  logic          w_pop, w_self_redir, w_redir, w_push, w_fifo_pop;

  fetch_fifo #(.FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .I_clk       (I_clk),
    .I_rst       (I_rst),
    .I_flush     (w_redir),
    .I_push      (w_push),
    .I_push_data ({r_fetch_pc, I_mem_data}),
    .I_pop       (w_fifo_pop),
    .O_full      (w_full),
    .O_empty     (w_empty),
    .O_count     (w_count),
    .O_head      (w_head)
  );

  assign w_head_pc = w_head[63:32];
  assign O_valid   = !w_empty;
  assign O_data    = w_empty ? 32'h0 : w_head[31:0];
  assign O_pc      = w_empty ? r_fetch_pc : w_head_pc;
  assign O_mem_req  = (r_state != ST_IDLE);
  assign O_mem_addr = word_align(r_fetch_pc);

  // A pop with a non-word step is a redirect to the halfword it names.
  assign w_pop        = O_valid && I_ready;
  assign w_self_redir = w_pop && (I_pcincr != PC_INCR_WORD);
  assign w_redir      = I_redirect || w_self_redir;
  assign w_target     = I_redirect ? I_target : (w_head_pc + I_pcincr);
  assign w_push       = (r_state == ST_REQ) && I_mem_ack && !w_redir;
  assign w_fifo_pop   = w_pop && !w_redir;

  always_comb begin
    w_count_after = w_count;
    if (w_push)     w_count_after = w_count_after + CW'(1);
    if (w_fifo_pop) w_count_after = w_count_after - CW'(1);
  end

  always_comb begin
    w_state_next    = r_state;
    w_fetch_pc_next = r_fetch_pc;
    w_pend_pc_next  = r_pend_pc;
    case (r_state)
      ST_IDLE: begin
        if (w_redir) begin
          w_state_next    = ST_REQ;
          w_fetch_pc_next = w_target;
        end else if (!w_full) begin
          w_state_next = ST_REQ;
        end
      end
      ST_REQ: begin
        if (I_mem_ack && w_redir) begin
          w_state_next    = ST_REQ;
          w_fetch_pc_next = w_target;
        end else if (I_mem_ack) begin
          w_fetch_pc_next = r_fetch_pc + PC_INCR_WORD;
          w_state_next    = (w_count_after < CW'(FIFO_DEPTH)) ? ST_REQ : ST_IDLE;
        end else if (w_redir) begin
          // The old request must stay on the bus until memory accepts it.
          w_state_next   = ST_DISCARD;
          w_pend_pc_next = w_target;
        end
      end
      ST_DISCARD: begin
        if (I_mem_ack) begin
          w_state_next    = ST_REQ;
          w_fetch_pc_next = w_redir ? w_target : r_pend_pc;
        end else if (w_redir) begin
          w_pend_pc_next = w_target;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge I_clk) begin
    if (I_rst) begin
      r_state    <= ST_IDLE;
      r_fetch_pc <= RESET_PC;
      r_pend_pc  <= RESET_PC;
    end else begin
      r_state    <= w_state_next;
      r_fetch_pc <= w_fetch_pc_next;
      r_pend_pc  <= w_pend_pc_next;
    end
  end

endmodule

// File: tb/tb_fetch.sv
// Bench for fetch: directed scenarios plus random traffic, checked by a
// scoreboard of expected architectural PCs and a memory-protocol monitor.
module tb_fetch;

  localparam logic [31:0] RESET_PC   = 32'h0000_0000;
  localparam int          FIFO_DEPTH = 2;

  logic        I_clk = 1'b0;
  logic        I_rst = 1'b1;
  logic [31:0] I_pcincr = 32'd4;
  logic        I_redirect = 1'b0;
  logic [31:0] I_target = 32'h0;
  logic        O_mem_req;
  logic [31:0] O_mem_addr;
  logic        I_mem_ack = 1'b0;
  logic [31:0] I_mem_data = 32'h0;
  logic        O_valid;
  logic [31:0] O_data;
  logic [31:0] O_pc;
  logic        I_ready = 1'b0;

  always #5 I_clk = ~I_clk;

  fetch #(.RESET_PC(RESET_PC), .FIFO_DEPTH(FIFO_DEPTH)) dut (
    .I_clk      (I_clk),
    .I_rst      (I_rst),
    .I_pcincr   (I_pcincr),
    .I_redirect (I_redirect),
    .I_target   (I_target),
    .O_mem_req  (O_mem_req),
    .O_mem_addr (O_mem_addr),
    .I_mem_ack  (I_mem_ack),
    .I_mem_data (I_mem_data),
    .O_valid    (O_valid),
    .O_data     (O_data),
    .O_pc       (O_pc),
    .I_ready    (I_ready)
  );

  int          n_checks = 0;
  int          n_pass   = 0;
  logic [31:0] exp_q[$];
  int          ack_mode = 0;  // 0: always ack, 1: random ack, 2: never ack
  int          ack_cnt  = 0;
  int          req_cnt  = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[31:2], 2'b00} ^ 32'hA5A5_A5A5;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h, required %h", name, act, exp);
  endtask

  task automatic step();
    @(negedge I_clk);
  endtask

  task automatic expect_restart(input logic [31:0] pc);
    exp_q.delete();
    exp_q.push_back(pc);
  endtask

  task automatic do_reset();
    I_rst = 1'b1;
    I_redirect = 1'b0;
    expect_restart(RESET_PC);
    step();
    step();
    I_rst = 1'b0;
  endtask

  // Instruction memory: data is a fixed function of the word address.
  initial forever begin
    @(negedge I_clk);
    #1;
    if (O_mem_req === 1'b1 &&
        (ack_mode == 0 || (ack_mode == 1 && $urandom_range(0, 1) == 1))) begin
      I_mem_ack  = 1'b1;
      I_mem_data = mem_word(O_mem_addr);
    end else begin
      I_mem_ack  = 1'b0;
      I_mem_data = $urandom;
    end
  end

  // Monitor: protocol checks and in-order comparison of every accepted word.
  initial begin
    logic        pend_prev;
    logic [31:0] pend_addr;
    logic [31:0] e;
    pend_prev = 1'b0;
    pend_addr = 32'h0;
    forever begin
      @(negedge I_clk);
      #3;
      if (I_rst) begin
        pend_prev = 1'b0;
      end else begin
        if (pend_prev) begin
          chk("req_hold", 32'(O_mem_req), 32'd1);
          chk("addr_hold", O_mem_addr, pend_addr);
        end
        if (O_mem_req) begin
          req_cnt++;
          chk("addr_align", 32'(O_mem_addr[1:0]), 32'd0);
          if (I_mem_ack) ack_cnt++;
        end
        if (!I_redirect && O_valid && I_ready) begin
          if (exp_q.size() == 0) begin
            n_checks++;
            $display("FAIL pop_unexpected: got word at O_pc %h, required none", O_pc);
          end else begin
            e = exp_q.pop_front();
            chk("pop_pc", O_pc, e);
            chk("pop_data", O_data, mem_word(e));
            exp_q.push_back(e + I_pcincr);
          end
        end
        pend_prev = O_mem_req && !I_mem_ack;
        pend_addr = O_mem_addr;
      end
    end
  end

  initial begin
    int nv, a0, q0, r;
    bit found;

    // Reset state, first-word latency and steady-state throughput.
    ack_mode = 0;
    I_ready  = 1'b1;
    I_pcincr = 32'd4;
    do_reset();
    chk("rst_req", 32'(O_mem_req), 32'd0);
    chk("rst_valid", 32'(O_valid), 32'd0);
    chk("rst_pc", O_pc, RESET_PC);
    chk("rst_data", O_data, 32'h0);
    chk("rst_addr", O_mem_addr, RESET_PC);
    step();
    chk("c1_valid", 32'(O_valid), 32'd0);
    chk("c1_req", 32'(O_mem_req), 32'd1);
    step();
    chk("c2_valid", 32'(O_valid), 32'd1);
    nv = 0;
    for (int i = 0; i < 8; i++) begin
      if (O_valid) nv++;
      step();
    end
    chk("throughput", 32'(nv), 32'd8);

    // Decode stalls: buffer fills, requests stop, stream resumes intact.
    I_ready = 1'b0;
    a0 = ack_cnt;
    q0 = req_cnt;
    repeat (5) step();
    // One word is already buffered when streaming at one word per cycle.
    chk("stall_acks", 32'(ack_cnt - a0), 32'(FIFO_DEPTH - 1));
    chk("stall_req_cycles", 32'(req_cnt - q0), 32'd1);
    chk("stall_valid", 32'(O_valid), 32'd1);
    I_ready = 1'b1;
    repeat (10) step();

    // Redirect while a request to 0x8 waits for its ack.
    I_ready = 1'b0;
    do_reset();
    repeat (4) step();
    ack_mode = 2;
    I_ready  = 1'b1;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (O_mem_req && O_mem_addr == 32'h8) found = 1'b1;
      else step();
    end
    chk("disc_found_req8", 32'(found), 32'd1);
    I_redirect = 1'b1;
    I_target   = 32'h100;
    expect_restart(32'h100);
    step();
    I_redirect = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("disc_hold_req", 32'(O_mem_req), 32'd1);
      chk("disc_hold_addr", O_mem_addr, 32'h8);
      chk("disc_flushed", 32'(O_valid), 32'd0);
      if (i == 2) ack_mode = 0;
      step();
    end
    chk("disc_new_req", 32'(O_mem_req), 32'd1);
    chk("disc_new_addr", O_mem_addr, 32'h100);
    step();
    chk("disc_valid", 32'(O_valid), 32'd1);
    chk("disc_pc", O_pc, 32'h100);
    repeat (6) step();

    // Halfword step on pop at 0x10 acts as a self-redirect.
    I_redirect = 1'b1;
    I_target   = 32'h10;
    expect_restart(32'h10);
    step();
    I_redirect = 1'b0;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (O_valid && O_pc == 32'h10) found = 1'b1;
      else step();
    end
    chk("half_found_pc10", 32'(found), 32'd1);
    I_pcincr = 32'd2;
    step();
    I_pcincr = 32'd4;
    chk("half_req", 32'(O_mem_req), 32'd1);
    chk("half_addr", O_mem_addr, 32'h10);
    chk("half_flushed", 32'(O_valid), 32'd0);
    step();
    chk("half_valid", 32'(O_valid), 32'd1);
    chk("half_pc", O_pc, 32'h12);
    repeat (6) step();

    // Redirect and pop together with a full buffer; 2-cycle redirect latency.
    I_ready = 1'b0;
    repeat (4) step();
    chk("full_noreq", 32'(O_mem_req), 32'd0);
    chk("full_valid", 32'(O_valid), 32'd1);
    I_ready    = 1'b1;
    I_redirect = 1'b1;
    I_target   = 32'h200;
    expect_restart(32'h200);
    step();
    I_redirect = 1'b0;
    chk("rdpop_flushed", 32'(O_valid), 32'd0);
    chk("rdpop_req", 32'(O_mem_req), 32'd1);
    chk("rdpop_addr", O_mem_addr, 32'h200);
    step();
    chk("rdpop_valid", 32'(O_valid), 32'd1);
    chk("rdpop_pc", O_pc, 32'h200);
    repeat (4) step();

    // Reset with a request outstanding.
    ack_mode = 2;
    found = 1'b0;
    for (int i = 0; i < 20 && !found; i++) begin
      if (O_mem_req) found = 1'b1;
      else step();
    end
    chk("rstmid_found_req", 32'(found), 32'd1);
    I_rst = 1'b1;
    expect_restart(RESET_PC);
    step();
    I_rst    = 1'b0;
    ack_mode = 0;
    chk("rstmid_req", 32'(O_mem_req), 32'd0);
    chk("rstmid_valid", 32'(O_valid), 32'd0);
    chk("rstmid_pc", O_pc, RESET_PC);
    chk("rstmid_addr", O_mem_addr, RESET_PC);
    step();
    step();
    chk("rstmid_restart_valid", 32'(O_valid), 32'd1);
    chk("rstmid_restart_pc", O_pc, RESET_PC);
    repeat (4) step();

    // Random traffic: stalls, random acks, redirects, halfword steps, resets.
    ack_mode = 1;
    for (int i = 0; i < 800; i++) begin
      I_rst      = 1'b0;
      I_redirect = 1'b0;
      r = int'($urandom_range(0, 299));
      if (r == 0) begin
        I_rst = 1'b1;
        expect_restart(RESET_PC);
      end else if (r < 10) begin
        I_redirect = 1'b1;
        I_target   = $urandom & 32'h0000_FFFE;
        expect_restart(I_target);
      end
      I_ready  = ($urandom_range(0, 3) != 0);
      I_pcincr = ($urandom_range(0, 7) == 0) ? 32'd2 : 32'd4;
      step();
    end
    I_rst      = 1'b0;
    I_redirect = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
